// File: rtl/pc_fetch_queue.sv
// pc_fetch_queue: program counter and fetch stage with a DEPTH-entry prefetch
// queue in front of decode. Redirects flush the queue and restart fetch.
`default_nettype none

module pc_fetch_queue #(
  parameter int unsigned    AW       = 8,
  parameter int unsigned    IW       = 20,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         redirect_valid,
  input  logic [AW-1:0]                redirect_pc,
  output logic                         mem_en,
  output logic [AW-1:0]                mem_addr,
  input  logic [IW-1:0]                mem_rdata,
  output logic                         ins_valid,
  output logic [IW-1:0]                ins,
  output logic [AW-1:0]                ins_pc,
  input  logic                         ins_ready,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;
  logic          kill_q, kill_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] instr_q [DEPTH];
  logic [AW-1:0] ipc_q   [DEPTH];

  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;

  // Outstanding request is reserved a slot, so the queue can never overflow.
  assign occupancy = {1'b0, count_q} + (CW+1)'(inflight_q);
  assign issue     = !reset && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign push      = inflight_q && !kill_q && !redirect_valid;
  assign ins_valid = (count_q != '0);
  assign pop       = ins_valid && ins_ready && !redirect_valid;

  assign mem_en    = issue;
  assign mem_addr  = pc_q;
  assign q_count   = count_q;
  assign ins       = ins_valid ? instr_q[rd_ptr_q] : '0;
  assign ins_pc    = ins_valid ? ipc_q[rd_ptr_q]   : '0;

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    kill_d     = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      kill_d   = inflight_q;
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (issue) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + AW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (!push && pop) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_q[i] <= '0;
        ipc_q[i]   <= '0;
      end
    end else if (push) begin
      instr_q[wr_ptr_q] <= mem_rdata;
      ipc_q[wr_ptr_q]   <= req_pc_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_queue.sv
// Self-checking bench for pc_fetch_queue: queue-level reference model plus
// directed scenarios with hand-computed expectations.
`default_nettype none

module tb_pc_fetch_queue;

  localparam int        AW    = 8;
  localparam int        IW    = 20;
  localparam int        DEPTH = 4;
  localparam logic [7:0] RPC  = 8'h10;

  logic          clk;
  logic          reset;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_rdata;
  logic          ins_valid;
  logic [IW-1:0] ins;
  logic [AW-1:0] ins_pc;
  logic          ins_ready;
  logic [2:0]    q_count;

  pc_fetch_queue #(
    .AW(AW), .IW(IW), .DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .mem_en(mem_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .ins_valid(ins_valid),
    .ins(ins),
    .ins_pc(ins_pc),
    .ins_ready(ins_ready),
    .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory: 1-cycle read latency, content = address ^ 0xAAAAA.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= {{(IW-AW){1'b0}}, mem_addr} ^ 20'hAAAAA;
  end

  typedef struct packed {
    logic [IW-1:0] d;
    logic [AW-1:0] a;
  } ent_t;

  ent_t       mq[$];
  logic [7:0] mpc;
  bit         mpend;
  ent_t       mpend_e;
  int         checks = 0;
  int         errors = 0;
  int         issues;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc   = RPC;
    mpend = 1'b0;
  endtask

  // One clock of the reference: returns land at the tail, decode takes the
  // head, a redirect throws everything away and restarts at the target.
  task automatic model_clock();
    int sz;
    bit iss;
    bit dopop;
    sz    = mq.size();
    iss   = !redirect_valid && (sz + int'(mpend) < DEPTH);
    dopop = !redirect_valid && (sz > 0) && ins_ready;
    if (dopop) void'(mq.pop_front());
    if (mpend && !redirect_valid) mq.push_back(mpend_e);
    if (redirect_valid) begin
      mq.delete();
      mpc   = redirect_pc;
      mpend = 1'b0;
    end else if (iss) begin
      mpend_e.d = {{(IW-AW){1'b0}}, mpc} ^ 20'hAAAAA;
      mpend_e.a = mpc;
      mpend     = 1'b1;
      mpc       = mpc + 8'd1;
    end else begin
      mpend = 1'b0;
    end
  endtask

  task automatic compare();
    bit   exp_en;
    ent_t h;
    exp_en = !reset && !redirect_valid && (mq.size() + int'(mpend) < DEPTH);
    h = '0;
    if (mq.size() > 0) h = mq[0];
    chk("mem_en",    32'(mem_en),    32'(exp_en));
    chk("mem_addr",  32'(mem_addr),  32'(mpc));
    chk("ins_valid", 32'(ins_valid), 32'(mq.size() > 0));
    chk("ins",       32'(ins),       32'(h.d));
    chk("ins_pc",    32'(ins_pc),    32'(h.a));
    chk("q_count",   32'(q_count),   32'(mq.size()));
  endtask

  task automatic cyc(input bit r, input logic [7:0] t, input bit rd);
    redirect_valid = r;
    redirect_pc    = t;
    ins_ready      = rd;
    #1;
    compare();
  endtask

  task automatic step(input bit r, input logic [7:0] t, input bit rd);
    @(posedge clk);
    model_clock();
    @(negedge clk);
    cyc(r, t, rd);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    ins_ready      = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    compare();
    chk("rst_mem_en",    32'(mem_en),    32'h0);
    chk("rst_mem_addr",  32'(mem_addr),  32'h10);
    chk("rst_ins_valid", 32'(ins_valid), 32'h0);
    chk("rst_q_count",   32'(q_count),   32'h0);
    chk("rst_ins_pc",    32'(ins_pc),    32'h0);
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ins_ready      = 1'b0;
    model_reset();
    @(negedge clk);

    // Straight-line fetch from reset
    do_reset();
    cyc(1'b0, 8'h00, 1'b1);
    chk("t1_c1_en",   32'(mem_en),   32'h1);
    chk("t1_c1_addr", 32'(mem_addr), 32'h10);
    step(1'b0, 8'h00, 1'b1);
    chk("t1_c2_addr",  32'(mem_addr),  32'h11);
    chk("t1_c2_valid", 32'(ins_valid), 32'h0);
    step(1'b0, 8'h00, 1'b1);
    chk("t1_c3_valid", 32'(ins_valid), 32'h1);
    chk("t1_c3_pc",    32'(ins_pc),    32'h10);
    chk("t1_c3_ins",   32'(ins),       32'hAAABA);
    step(1'b0, 8'h00, 1'b1);
    chk("t1_c4_pc",  32'(ins_pc), 32'h11);
    chk("t1_c4_ins", 32'(ins),    32'hAAABB);
    repeat (6) step(1'b0, 8'h00, 1'b1);

    // Stall from reset fills the queue, then drain
    do_reset();
    cyc(1'b0, 8'h00, 1'b0);
    issues = int'(mem_en);
    repeat (7) begin
      step(1'b0, 8'h00, 1'b0);
      issues += int'(mem_en);
    end
    chk("t2_issues",  32'(issues),   32'd4);
    chk("t2_full",    32'(q_count),  32'd4);
    chk("t2_en_low",  32'(mem_en),   32'h0);
    chk("t2_head",    32'(ins_pc),   32'h10);
    chk("t2_pc_hold", 32'(mem_addr), 32'h14);
    step(1'b0, 8'h00, 1'b1);
    chk("t2_drain0", 32'(ins_pc), 32'h10);
    step(1'b0, 8'h00, 1'b1);
    chk("t2_drain1",  32'(ins_pc),   32'h11);
    chk("t2_resume",  32'(mem_en),   32'h1);
    chk("t2_res_adr", 32'(mem_addr), 32'h14);
    repeat (8) step(1'b0, 8'h00, 1'b1);

    // Redirect with 2 queued and 1 in flight
    do_reset();
    cyc(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h40, 1'b0);
    chk("t3_pre_cnt", 32'(q_count), 32'd2);
    step(1'b0, 8'h00, 1'b1);
    chk("t3_flushed", 32'(q_count),  32'd0);
    chk("t3_tgt_adr", 32'(mem_addr), 32'h40);
    step(1'b0, 8'h00, 1'b1);
    chk("t3_r2_empty", 32'(ins_valid), 32'h0);
    step(1'b0, 8'h00, 1'b1);
    chk("t3_r3_valid", 32'(ins_valid), 32'h1);
    chk("t3_r3_pc",    32'(ins_pc),    32'h40);
    repeat (4) step(1'b0, 8'h00, 1'b1);

    // Redirect near top of address space wraps
    step(1'b1, 8'hFE, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("t4_fe", 32'(ins_pc), 32'hFE);
    step(1'b0, 8'h00, 1'b1);
    chk("t4_ff", 32'(ins_pc), 32'hFF);
    step(1'b0, 8'h00, 1'b1);
    chk("t4_00", 32'(ins_pc), 32'h00);
    step(1'b0, 8'h00, 1'b1);
    chk("t4_01", 32'(ins_pc), 32'h01);

    // Redirect with ready high and a valid head: no pop
    step(1'b1, 8'h80, 1'b1);
    chk("t5_head_valid", 32'(ins_valid), 32'h1);
    step(1'b0, 8'h00, 1'b1);
    chk("t5_empty", 32'(q_count), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("t5_80", 32'(ins_pc), 32'h80);
    step(1'b0, 8'h00, 1'b1);
    chk("t5_81", 32'(ins_pc), 32'h81);
    repeat (4) step(1'b0, 8'h00, 1'b1);

    // Asynchronous reset pulse mid-cycle with 3 entries held
    do_reset();
    cyc(1'b0, 8'h00, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b0);
    chk("t6_pre_cnt", 32'(q_count), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("t6_valid", 32'(ins_valid), 32'h0);
    chk("t6_cnt",   32'(q_count),   32'd0);
    chk("t6_addr",  32'(mem_addr),  32'h10);
    chk("t6_en",    32'(mem_en),    32'h0);
    model_reset();
    reset = 1'b0;
    ins_ready = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("t6_resume_valid", 32'(ins_valid), 32'h1);
    chk("t6_resume_pc",    32'(ins_pc),    32'h10);
    repeat (5) step(1'b0, 8'h00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
